reg_bus_arb: RTL and testbench
==============================

// Module: reg_bus_arb
// PURPOSE
//  Two-port arbiter sharing the single register-file bus (read/write/addr/data_write/data_read)
//  between the SPI instruction decoder (port 0) and an on-chip requester such as the PWM
//  init/update sequencer (port 1). Each grant runs one transaction and drives exactly one
//  1-cycle read or write strobe. The regs block sees a single master.
// PARAMETERS
//  ADDR_W     6  register address width
//  DATA_W     8  register data width
//  PRIO_MODE  0  0 = round-robin between ports; 1 = fixed priority, port 0 always wins ties
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  p0_req      in   1       port 0 request, level, held until p0_ack
//  p0_we       in   1       port 0 direction: 1 = write, 0 = read
//  p0_addr     in   ADDR_W  port 0 register address
//  p0_wdata    in   DATA_W  port 0 write data
//  p0_ack      out  1       port 0 completion pulse, 1 cycle
//  p0_rdata    out  DATA_W  port 0 read data, valid with p0_ack, held until next p0 read
//  p1_req/p1_we/p1_addr/p1_wdata/p1_ack/p1_rdata  same as port 0, for port 1
//  read        out  1       bus read strobe to regs, 1 cycle
//  write       out  1       bus write strobe to regs, 1 cycle
//  addr        out  ADDR_W  bus address
//  data_write  out  DATA_W  bus write data
//  data_read   in   DATA_W  regs read data, combinational from addr
//  busy        out  1       high in XFER and ACK
//  grant_id    out  1       port owning the current or last transaction
// BEHAVIOUR
//  Reset: FSM=IDLE. read, write, addr, data_write, p0/p1_ack, p0/p1_rdata, busy and grant_id are 0.
//    last_grant resets to 1, so port 0 wins the first tie.
//    Reset asserted mid-transaction aborts it: strobe drops immediately, no ack is issued.
//  FSM IDLE -> XFER -> ACK -> IDLE. All outputs are registered.
//   IDLE: sample the req inputs. If any is high, pick a winner.
//     Latch the winner's we, addr and wdata into addr/data_write; set grant_id.
//     Set read=~we or write=we. Go to XFER.
//   XFER: the strobe is high for exactly this cycle, with addr and data_write stable.
//     Read: capture data_read into the winner's rdata at the end of this cycle. Then strobe=0, go to ACK.
//   ACK: winner's ack=1 for this cycle only; rdata is already valid. Update last_grant. Go to IDLE.
//  Latency: req high in IDLE cycle N -> strobe in cycle N+1 -> ack in cycle N+2.
//    Throughput is at most 1 transaction per 3 cycles.
//  Handshake: requester drops req on the edge where it sees ack=1.
//    req still high in the IDLE cycle after ack is a new transaction.
//    req dropped while in XFER/ACK is ignored: the transaction was latched and completes.
//    req/we/addr/wdata changes after grant have no effect.
//  Arbitration, both reqs high in IDLE:
//    PRIO_MODE=0: grant the port != last_grant.
//    PRIO_MODE=1: grant port 0 always; port 1 may starve, by design.
//    One req high: grant that port regardless of mode.
//  Loser's req stays pending and is re-evaluated in the next IDLE.
//  read and write are never high together. Strobes never occur outside XFER.
//  busy=1 in XFER and ACK. Non-granted port's ack stays 0 and its rdata is unchanged.
//  Writes never modify rdata. addr/data_write hold their last values in IDLE.
// TESTING
//  T1 p0 write 0x05<-0xA5 alone -> write=1 one cycle, addr=0x05, data_write=0xA5, p0_ack at req+2, read never high.
//  T2 p1 read 0x02, regs returns 0x3C -> read=1 one cycle, p1_rdata=0x3C with p1_ack; p0_rdata stays 0.
//  T3 PRIO_MODE=0, both reqs held for 4 transactions -> grants p0,p1,p0,p1; acks 3 cycles apart.
//  T4 PRIO_MODE=1, both reqs held -> p0 granted every time, p1_ack never asserts until p0_req drops.
//  T5 p0 drops req and changes addr in XFER -> transaction completes to the latched addr, p0_ack still pulses.
//  T6 rst_n low during XFER of a write -> write=0 asynchronously, no ack.
//    After release: FSM IDLE, pending req served normally.

Source files
------------

// File: rtl/reg_bus_arb_if.sv
// Register-bus arbiter interface: two requester ports plus the shared
// register-file bus. The arbiter uses the master modport; the requesters and
// the register file use the slave modport.
interface reg_bus_arb_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);

  // Port 0 (SPI instruction decoder)
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  // Port 1 (on-chip sequencer)
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  // Shared register-file bus
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_write;
  logic [DATA_W-1:0] data_read;

  // Status
  logic              busy;
  logic              grant_id;

  modport master (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  data_read,
    output p0_ack, p0_rdata,
    output p1_ack, p1_rdata,
    output read, write, addr, data_write,
    output busy, grant_id
  );

  modport slave (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output data_read,
    input  p0_ack, p0_rdata,
    input  p1_ack, p1_rdata,
    input  read, write, addr, data_write,
    input  busy, grant_id
  );

endinterface

// File: rtl/reg_bus_arb.sv
// Two-port arbiter for the register-file bus. Each grant runs exactly one
// transaction (IDLE -> XFER -> ACK) and produces a single 1-cycle read or
// write strobe, so the register file only ever sees one master.
// PRIO_MODE 0 alternates between ports on a tie; PRIO_MODE 1 always favours
// port 0 (port 1 may starve while port 0 keeps requesting).
module reg_bus_arb #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int PRIO_MODE = 0
) (
  input logic           clk,
  input logic           rst_n,
  reg_bus_arb_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state;

  // Port that owned the most recent completed transaction. Reset to 1 so the
  // very first tie goes to port 0.
  logic last_grant;

  // Winner selection for the current IDLE cycle
  logic              any_req;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Pick the winning port and mux its request fields.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    any_req = bus.p0_req | bus.p1_req;
    win     = 1'b0;
    if (bus.p0_req && bus.p1_req) begin
      win = (PRIO_MODE == 1) ? 1'b0 : ~last_grant;
    end else if (bus.p1_req) begin
      win = 1'b1;
    end
    sel_we    = win ? bus.p1_we    : bus.p0_we;
    sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;
  end

  // Transaction FSM; every output is a register so the bus is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: reset is asynchronous, so a strobe in flight drops the moment
    // rst_n falls and no ack is ever issued for the aborted transaction.
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.addr       <= '0;
      bus.data_write <= '0;
      bus.p0_ack     <= 1'b0;
      bus.p1_ack     <= 1'b0;
      bus.p0_rdata   <= '0;
      bus.p1_rdata   <= '0;
      bus.busy       <= 1'b0;
      bus.grant_id   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout: every register updates
      // from the values of the previous cycle, independent of statement order.
      case (state)
        IDLE: begin
          if (any_req) begin
            // Latch the winner's request; later input changes are ignored.
            bus.grant_id   <= win;
            bus.addr       <= sel_addr;
            bus.data_write <= sel_wdata;
            bus.read       <= ~sel_we;
            bus.write      <= sel_we;
            bus.busy       <= 1'b1;
            state          <= XFER;
          end
        end

        XFER: begin
          // Strobe is high for this cycle only; a read captures the register
          // file's combinational data at the end of it.
          bus.read  <= 1'b0;
          bus.write <= 1'b0;
          if (bus.read) begin
            if (bus.grant_id) bus.p1_rdata <= bus.data_read;
            else              bus.p0_rdata <= bus.data_read;
          end
          if (bus.grant_id) bus.p1_ack <= 1'b1;
          else              bus.p0_ack <= 1'b1;
          state <= ACK;
        end

        ACK: begin
          // Completion pulse ends; remember the owner for round-robin.
          bus.p0_ack <= 1'b0;
          bus.p1_ack <= 1'b0;
          bus.busy   <= 1'b0;
          last_grant <= bus.grant_id;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed testbench for reg_bus_arb. Two instances are built: one in
// round-robin mode and one in fixed-priority mode. The register file is
// modelled as a combinational read of data_read = {2'b00, addr} ^ 8'h3E.
module tb_reg_bus_arb;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  reg_bus_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rr_if ();
  reg_bus_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fp_if ();

  reg_bus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(0)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rr_if.master)
  );

  reg_bus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(1)) u_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fp_if.master)
  );

  assign rr_if.data_read = {2'b00, rr_if.addr} ^ 8'h3E;
  assign fp_if.data_read = {2'b00, fp_if.addr} ^ 8'h3E;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and sample 1 time unit after the rising edge; the
  // bus-level invariants are checked on every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    n_vec++;
    if ((rr_if.read & rr_if.write) !== 1'b0 || ((rr_if.read | rr_if.write) & ~rr_if.busy) !== 1'b0) begin
      n_err++;
      $display("FAIL rr_strobe_inv: read=%b write=%b busy=%b required no overlap and strobe only when busy",
               rr_if.read, rr_if.write, rr_if.busy);
    end
    n_vec++;
    if ((fp_if.read & fp_if.write) !== 1'b0 || ((fp_if.read | fp_if.write) & ~fp_if.busy) !== 1'b0) begin
      n_err++;
      $display("FAIL fp_strobe_inv: read=%b write=%b busy=%b required no overlap and strobe only when busy",
               fp_if.read, fp_if.write, fp_if.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rr_if.p0_req = 0; rr_if.p0_we = 0; rr_if.p0_addr = '0; rr_if.p0_wdata = '0;
    rr_if.p1_req = 0; rr_if.p1_we = 0; rr_if.p1_addr = '0; rr_if.p1_wdata = '0;
    fp_if.p0_req = 0; fp_if.p0_we = 0; fp_if.p0_addr = '0; fp_if.p0_wdata = '0;
    fp_if.p1_req = 0; fp_if.p1_we = 0; fp_if.p1_addr = '0; fp_if.p1_wdata = '0;
    tick();
    tick();
    n_vec++;
    if ({rr_if.read, rr_if.write, rr_if.addr, rr_if.data_write, rr_if.p0_ack, rr_if.p1_ack,
         rr_if.p0_rdata, rr_if.p1_rdata, rr_if.busy, rr_if.grant_id} !== '0) begin
      n_err++;
      $display("FAIL reset_rr: outputs not all zero (addr=%h dw=%h busy=%b)", rr_if.addr, rr_if.data_write, rr_if.busy);
    end
    n_vec++;
    if ({fp_if.read, fp_if.write, fp_if.addr, fp_if.data_write, fp_if.p0_ack, fp_if.p1_ack,
         fp_if.p0_rdata, fp_if.p1_rdata, fp_if.busy, fp_if.grant_id} !== '0) begin
      n_err++;
      $display("FAIL reset_fp: outputs not all zero (addr=%h dw=%h busy=%b)", fp_if.addr, fp_if.data_write, fp_if.busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // T1: port 0 write 0x05 <- 0xA5 on its own.
  task automatic test_p0_write();
    rr_if.p0_req = 1; rr_if.p0_we = 1; rr_if.p0_addr = 6'h05; rr_if.p0_wdata = 8'hA5;
    tick();
    n_vec++;
    if ({rr_if.write, rr_if.read, rr_if.addr, rr_if.data_write, rr_if.grant_id, rr_if.busy, rr_if.p0_ack}
        !== {1'b1, 1'b0, 6'h05, 8'hA5, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL t1_xfer: w=%b r=%b addr=%h dw=%h gid=%b busy=%b ack=%b required 1 0 05 a5 0 1 0",
               rr_if.write, rr_if.read, rr_if.addr, rr_if.data_write, rr_if.grant_id, rr_if.busy, rr_if.p0_ack);
    end
    tick();
    n_vec++;
    if ({rr_if.write, rr_if.read, rr_if.p0_ack, rr_if.p1_ack, rr_if.busy} !== 5'b00101) begin
      n_err++;
      $display("FAIL t1_ack: w=%b r=%b p0_ack=%b p1_ack=%b busy=%b required 0 0 1 0 1",
               rr_if.write, rr_if.read, rr_if.p0_ack, rr_if.p1_ack, rr_if.busy);
    end
    rr_if.p0_req = 0;
    tick();
    n_vec++;
    if ({rr_if.p0_ack, rr_if.busy, rr_if.addr, rr_if.data_write, rr_if.p0_rdata}
        !== {1'b0, 1'b0, 6'h05, 8'hA5, 8'h00}) begin
      n_err++;
      $display("FAIL t1_idle: ack=%b busy=%b addr=%h dw=%h p0_rdata=%h required 0 0 05 a5 00",
               rr_if.p0_ack, rr_if.busy, rr_if.addr, rr_if.data_write, rr_if.p0_rdata);
    end
  endtask

  // T2: port 1 read of 0x02; register file returns 0x02 ^ 0x3E = 0x3C.
  task automatic test_p1_read();
    rr_if.p1_req = 1; rr_if.p1_we = 0; rr_if.p1_addr = 6'h02; rr_if.p1_wdata = 8'h99;
    tick();
    n_vec++;
    if ({rr_if.read, rr_if.write, rr_if.addr, rr_if.grant_id} !== {1'b1, 1'b0, 6'h02, 1'b1}) begin
      n_err++;
      $display("FAIL t2_xfer: r=%b w=%b addr=%h gid=%b required 1 0 02 1",
               rr_if.read, rr_if.write, rr_if.addr, rr_if.grant_id);
    end
    tick();
    n_vec++;
    if ({rr_if.read, rr_if.p1_ack, rr_if.p0_ack, rr_if.p1_rdata, rr_if.p0_rdata}
        !== {1'b0, 1'b1, 1'b0, 8'h3C, 8'h00}) begin
      n_err++;
      $display("FAIL t2_ack: r=%b p1_ack=%b p0_ack=%b p1_rdata=%h p0_rdata=%h required 0 1 0 3c 00",
               rr_if.read, rr_if.p1_ack, rr_if.p0_ack, rr_if.p1_rdata, rr_if.p0_rdata);
    end
    rr_if.p1_req = 0;
    tick();
    n_vec++;
    if ({rr_if.p1_ack, rr_if.p1_rdata, rr_if.busy} !== {1'b0, 8'h3C, 1'b0}) begin
      n_err++;
      $display("FAIL t2_hold: p1_ack=%b p1_rdata=%h busy=%b required 0 3c 0",
               rr_if.p1_ack, rr_if.p1_rdata, rr_if.busy);
    end
  endtask

  // T3: round-robin, both requests held. Last owner was port 1, so the
  // order is p0, p1, p0, p1 with acks every 3 cycles.
  task automatic test_round_robin();
    logic exp_id;
    rr_if.p0_req = 1; rr_if.p0_we = 1; rr_if.p0_addr = 6'h10; rr_if.p0_wdata = 8'h11;
    rr_if.p1_req = 1; rr_if.p1_we = 0; rr_if.p1_addr = 6'h20; rr_if.p1_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      tick();
      n_vec++;
      if ({rr_if.grant_id, rr_if.write, rr_if.read, rr_if.addr}
          !== {exp_id, ~exp_id, exp_id, (exp_id ? 6'h20 : 6'h10)}) begin
        n_err++;
        $display("FAIL t3_grant%0d: gid=%b w=%b r=%b addr=%h required gid=%b", i,
                 rr_if.grant_id, rr_if.write, rr_if.read, rr_if.addr, exp_id);
      end
      tick();
      n_vec++;
      if ({rr_if.p0_ack, rr_if.p1_ack} !== {~exp_id, exp_id}) begin
        n_err++;
        $display("FAIL t3_ack%0d: p0_ack=%b p1_ack=%b required %b %b", i,
                 rr_if.p0_ack, rr_if.p1_ack, ~exp_id, exp_id);
      end
      if (exp_id) begin
        n_vec++;
        if (rr_if.p1_rdata !== 8'h1E) begin
          n_err++;
          $display("FAIL t3_rdata%0d: p1_rdata=%h required 1e", i, rr_if.p1_rdata);
        end
      end
      tick();
      n_vec++;
      if ({rr_if.p0_ack, rr_if.p1_ack, rr_if.busy} !== 3'b000) begin
        n_err++;
        $display("FAIL t3_idle%0d: p0_ack=%b p1_ack=%b busy=%b required 0 0 0", i,
                 rr_if.p0_ack, rr_if.p1_ack, rr_if.busy);
      end
    end
    rr_if.p0_req = 0;
    rr_if.p1_req = 0;
    tick();
  endtask

  // T4: fixed priority, both held. Port 0 wins every time; port 1 only gets
  // in once port 0 drops its request.
  task automatic test_fixed_prio();
    fp_if.p0_req = 1; fp_if.p0_we = 0; fp_if.p0_addr = 6'h01; fp_if.p0_wdata = 8'h00;
    fp_if.p1_req = 1; fp_if.p1_we = 1; fp_if.p1_addr = 6'h07; fp_if.p1_wdata = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({fp_if.grant_id, fp_if.read, fp_if.addr} !== {1'b0, 1'b1, 6'h01}) begin
        n_err++;
        $display("FAIL t4_grant%0d: gid=%b r=%b addr=%h required 0 1 01", i,
                 fp_if.grant_id, fp_if.read, fp_if.addr);
      end
      tick();
      n_vec++;
      if ({fp_if.p0_ack, fp_if.p1_ack, fp_if.p0_rdata} !== {1'b1, 1'b0, 8'h3F}) begin
        n_err++;
        $display("FAIL t4_ack%0d: p0_ack=%b p1_ack=%b p0_rdata=%h required 1 0 3f", i,
                 fp_if.p0_ack, fp_if.p1_ack, fp_if.p0_rdata);
      end
      tick();
    end
    fp_if.p0_req = 0;
    tick();
    n_vec++;
    if ({fp_if.grant_id, fp_if.write, fp_if.addr, fp_if.data_write} !== {1'b1, 1'b1, 6'h07, 8'h77}) begin
      n_err++;
      $display("FAIL t4_p1_grant: gid=%b w=%b addr=%h dw=%h required 1 1 07 77",
               fp_if.grant_id, fp_if.write, fp_if.addr, fp_if.data_write);
    end
    tick();
    n_vec++;
    if ({fp_if.p1_ack, fp_if.p0_ack, fp_if.p1_rdata} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL t4_p1_ack: p1_ack=%b p0_ack=%b p1_rdata=%h required 1 0 00",
               fp_if.p1_ack, fp_if.p0_ack, fp_if.p1_rdata);
    end
    fp_if.p1_req = 0;
    tick();
  endtask

  // T5: port 0 drops req and changes its fields during XFER; the latched
  // transaction still completes.
  task automatic test_req_drop();
    rr_if.p0_req = 1; rr_if.p0_we = 1; rr_if.p0_addr = 6'h0A; rr_if.p0_wdata = 8'h5A;
    tick();
    n_vec++;
    if ({rr_if.write, rr_if.addr, rr_if.data_write} !== {1'b1, 6'h0A, 8'h5A}) begin
      n_err++;
      $display("FAIL t5_xfer: w=%b addr=%h dw=%h required 1 0a 5a", rr_if.write, rr_if.addr, rr_if.data_write);
    end
    rr_if.p0_req = 0; rr_if.p0_we = 0; rr_if.p0_addr = 6'h3F; rr_if.p0_wdata = 8'hFF;
    tick();
    n_vec++;
    if ({rr_if.p0_ack, rr_if.addr, rr_if.data_write, rr_if.write, rr_if.read}
        !== {1'b1, 6'h0A, 8'h5A, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL t5_ack: ack=%b addr=%h dw=%h w=%b r=%b required 1 0a 5a 0 0",
               rr_if.p0_ack, rr_if.addr, rr_if.data_write, rr_if.write, rr_if.read);
    end
    tick();
    tick();
    n_vec++;
    if ({rr_if.busy, rr_if.read, rr_if.write, rr_if.addr} !== {1'b0, 1'b0, 1'b0, 6'h0A}) begin
      n_err++;
      $display("FAIL t5_idle: busy=%b r=%b w=%b addr=%h required 0 0 0 0a",
               rr_if.busy, rr_if.read, rr_if.write, rr_if.addr);
    end
  endtask

  // T6: reset during the XFER of a write aborts it; the still-pending request
  // is served after release.
  task automatic test_reset_abort();
    rr_if.p0_req = 1; rr_if.p0_we = 1; rr_if.p0_addr = 6'h33; rr_if.p0_wdata = 8'hC3;
    tick();
    n_vec++;
    if (rr_if.write !== 1'b1) begin
      n_err++;
      $display("FAIL t6_pre: write=%b required 1", rr_if.write);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rr_if.write, rr_if.busy, rr_if.p0_ack} !== 3'b000) begin
      n_err++;
      $display("FAIL t6_async: w=%b busy=%b ack=%b required 0 0 0", rr_if.write, rr_if.busy, rr_if.p0_ack);
    end
    tick();
    n_vec++;
    if ({rr_if.write, rr_if.p0_ack} !== 2'b00) begin
      n_err++;
      $display("FAIL t6_noack: w=%b ack=%b required 0 0", rr_if.write, rr_if.p0_ack);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({rr_if.write, rr_if.addr, rr_if.data_write, rr_if.grant_id} !== {1'b1, 6'h33, 8'hC3, 1'b0}) begin
      n_err++;
      $display("FAIL t6_retry: w=%b addr=%h dw=%h gid=%b required 1 33 c3 0",
               rr_if.write, rr_if.addr, rr_if.data_write, rr_if.grant_id);
    end
    tick();
    n_vec++;
    if (rr_if.p0_ack !== 1'b1) begin
      n_err++;
      $display("FAIL t6_ack: ack=%b required 1", rr_if.p0_ack);
    end
    rr_if.p0_req = 0;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_p0_write();
    test_p1_read();
    test_round_robin();
    test_fixed_prio();
    test_req_drop();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
